// File: rtl/dadda_cpa_seq.sv
// Final carry-propagate adder for the Dadda multiplier: resolves the CSA sum and
// carry vectors into a binary result, CHUNK bits per clock, with valid/ready on both sides.
module dadda_cpa_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   car_q, car_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;

  logic               last_chunk;
  logic [CHUNK:0]     chunk_sum;

  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
  assign chunk_sum  = {1'b0, sum_q[idx_q*CHUNK +: CHUNK]}
                    + {1'b0, car_q[idx_q*CHUNK +: CHUNK]}
                    + (CHUNK+1)'(carry_q);

  // State register and datapath registers share one synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= IDLE;
      // NOTE: operand registers are reset too, so an aborted operation leaves no trace.
      sum_q    <= '0;
      car_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      car_q    <= car_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
    end
  end

  always_comb begin
    // NOTE: default assignment first, so no path through this block can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = ADD;
      ADD:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    sum_d    = sum_q;
    car_d    = car_q;
    result_d = result_q;
    cout_d   = cout_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_d   = sum_vec;
          car_d   = carry_vec;
          idx_d   = '0;
          carry_d = 1'b0;
        end
      end
      ADD: begin
        result_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        // Index parks at 0 after the top chunk so it never addresses past WIDTH.
        idx_d   = last_chunk ? '0 : idx_q + IDX_W'(1);
        if (last_chunk) cout_d = chunk_sum[CHUNK];
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    cout      = cout_q;
  end

endmodule

// File: tb/tb_dadda_cpa_seq.sv
// Directed and random checks of dadda_cpa_seq at CHUNK=4 (dut_a) and CHUNK=16 (dut_b),
// with expected {cout,result} queued at accept and compared when out_valid rises.
module tb_dadda_cpa_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cout;
  logic [15:0] a_sum, a_car, a_result;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cout;
  logic [15:0] b_sum, b_car, b_result;

  int checks = 0;
  int errors = 0;
  logic [16:0] a_q[$];
  logic [16:0] b_q[$];

  always #5 clk = ~clk;

  dadda_cpa_seq #(.WIDTH(16), .CHUNK(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sum_vec(a_sum), .carry_vec(a_car), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .result(a_result), .cout(a_cout)
  );

  dadda_cpa_seq #(.WIDTH(16), .CHUNK(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sum_vec(b_sum), .carry_vec(b_car), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .cout(b_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ov(input bit w);
    return w ? b_out_valid : a_out_valid;
  endfunction

  function automatic logic ir(input bit w);
    return w ? b_in_ready : a_in_ready;
  endfunction

  function automatic logic [16:0] res(input bit w);
    return w ? {b_cout, b_result} : {a_cout, a_result};
  endfunction

  // Drive one operand pair, check it is accepted, and queue the reference sum.
  task automatic accept(input bit w, input logic [15:0] s, input logic [15:0] c, input bit hold);
    logic [16:0] e;
    e = {1'b0, s} + {1'b0, c};
    if (w) begin b_sum = s; b_car = c; b_in_valid = 1'b1; end
    else   begin a_sum = s; a_car = c; a_in_valid = 1'b1; end
    check("in_ready_before_accept", 32'(ir(w)), 32'd1);
    tick();
    if (w) b_q.push_back(e); else a_q.push_back(e);
    if (!hold) begin
      if (w) b_in_valid = 1'b0; else a_in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for out_valid, checking latency, in_ready low, and the result.
  task automatic wait_out(input bit w, input string tag, input int exp_lat);
    int n;
    logic [16:0] e;
    n = 0;
    while (!ov(w) && n < 50) begin
      check({tag, "_in_ready_busy"}, 32'(ir(w)), 32'd0);
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_in_ready_done"}, 32'(ir(w)), 32'd0);
    if (w) e = (b_q.size() != 0) ? b_q.pop_front() : 'x;
    else   e = (a_q.size() != 0) ? a_q.pop_front() : 'x;
    check({tag, "_result"}, 32'(res(w)), 32'(e));
  endtask

  task automatic finish_op(input bit w, input string tag);
    if (w) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    tick();
    if (w) b_out_ready = 1'b0; else a_out_ready = 1'b0;
    check({tag, "_out_valid_after_hs"}, 32'(ov(w)), 32'd0);
    check({tag, "_in_ready_after_hs"}, 32'(ir(w)), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] s, c;
    int n;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_sum = '0; a_car = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_sum = '0; b_car = '0;
    tick();
    tick();
    check("rst_in_ready_a", 32'(a_in_ready), 32'd0);
    check("rst_in_ready_b", 32'(b_in_ready), 32'd0);
    check("rst_out_valid_a", 32'(a_out_valid), 32'd0);
    check("rst_result_a", 32'(res(1'b0)), 32'd0);
    check("rst_result_b", 32'(res(1'b1)), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready_a", 32'(a_in_ready), 32'd1);

    // Carry ripples through every chunk into cout.
    accept(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    wait_out(1'b0, "t1_ripple", 4);
    check("t1_exact_value", 32'(res(1'b0)), 32'h1_0000);
    finish_op(1'b0, "t1");

    accept(1'b0, 16'h1234, 16'h4321, 1'b0);
    wait_out(1'b0, "t2_plain", 4);
    finish_op(1'b0, "t2");

    // Backpressure: result held, new operands ignored while DONE.
    accept(1'b0, 16'h0F0F, 16'h00F1, 1'b0);
    wait_out(1'b0, "t3_bp", 4);
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1;
      a_sum = 16'($urandom);
      a_car = 16'($urandom);
      tick();
      check("t3_hold_out_valid", 32'(a_out_valid), 32'd1);
      check("t3_hold_in_ready", 32'(a_in_ready), 32'd0);
      check("t3_hold_result", 32'(res(1'b0)), 32'h0_1000);
    end
    a_in_valid = 1'b0;
    finish_op(1'b0, "t3");
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t3_no_capture", 32'(a_out_valid), 32'd0);
    end

    // Reset after two ADD edges discards the operation.
    accept(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    a_q.delete();
    #1;
    check("t4_in_ready_in_rst", 32'(a_in_ready), 32'd0);
    tick();
    check("t4_out_valid", 32'(a_out_valid), 32'd0);
    check("t4_result_cleared", 32'(res(1'b0)), 32'd0);
    rst_n = 1'b1;
    #1;
    check("t4_in_ready_release", 32'(a_in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4_no_spurious_valid", 32'(a_out_valid), 32'd0);
    end

    // Back-to-back with in_valid and out_ready held high.
    a_out_ready = 1'b1;
    accept(1'b0, 16'h8000, 16'h8000, 1'b1);
    a_sum = 16'h00FF;
    a_car = 16'h0F01;
    wait_out(1'b0, "t5_first", 4);
    tick();
    check("t5_hs_out_valid", 32'(a_out_valid), 32'd0);
    check("t5_hs_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    a_q.push_back(17'h0_1000);
    check("t5_second_accepted", 32'(a_in_ready), 32'd0);
    wait_out(1'b0, "t5_second", 4);
    a_in_valid = 1'b0;
    tick();
    a_out_ready = 1'b0;
    check("t5_final_out_valid", 32'(a_out_valid), 32'd0);

    // Single-chunk configuration.
    accept(1'b1, 16'hAAAA, 16'h5555, 1'b0);
    wait_out(1'b1, "t6_wide", 1);
    finish_op(1'b1, "t6");
    accept(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    wait_out(1'b1, "t6_wide_wrap", 1);
    finish_op(1'b1, "t6w");

    // Random vectors into both configurations in parallel.
    for (int i = 0; i < 3000; i++) begin
      s = 16'($urandom);
      c = 16'($urandom);
      if (i % 16 == 0) s = 16'hFFFF;
      if (i % 16 == 1) c = 16'hFFFF;
      if (i % 16 == 2) c = ~s;
      a_sum = s; a_car = c; a_in_valid = 1'b1;
      b_sum = s; b_car = c; b_in_valid = 1'b1;
      tick();
      a_q.push_back({1'b0, s} + {1'b0, c});
      b_q.push_back({1'b0, s} + {1'b0, c});
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      n = 0;
      while (!(a_out_valid && b_out_valid) && n < 20) begin
        tick();
        n++;
      end
      check("rnd_latency", n, 4);
      check("rnd_a", 32'(res(1'b0)), 32'((a_q.size() != 0) ? a_q.pop_front() : 17'bx));
      check("rnd_b", 32'(res(1'b1)), 32'((b_q.size() != 0) ? b_q.pop_front() : 17'bx));
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      b_out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
